// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop synchroniser, start-edge detect, mid-bit sampling.
// Emits a one-cycle valid with the received byte, or a one-cycle framing-error pulse.
module uart_recv #(
  parameter int unsigned BIT_CNT = 100000,
  parameter int unsigned CW      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CW-1:0] HALF_END = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(BIT_CNT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_s_d;
  logic [1:0]    r_warm;
  logic          r_armed;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_busy;

  state_t        w_next_state;
  logic          w_fall;
  logic          w_half;
  logic          w_full;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_valid_nxt;
  logic          w_ferr_nxt;

  // Edges only count once s holds real line samples and has been seen high,
  // so a line held low through reset release cannot start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s_d   <= 1'b1;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= din;
      r_s2    <= r_s1;
      r_s_d   <= r_s2;
      r_warm  <= {r_warm[0], 1'b1};
      r_armed <= r_armed | (r_warm[1] & r_s2);
    end
  end

  assign w_fall = r_armed & r_s_d & ~r_s2;
  assign w_half = (r_cnt == HALF_END);
  assign w_full = (r_cnt == FULL_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_next_state = START;
      START: if (w_half) w_next_state = r_s2 ? IDLE : DATA;
      DATA:  if (w_full && (r_bit_idx == 3'd7)) w_next_state = STOP;
      STOP:  if (w_full) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      IDLE: w_cnt_nxt = '0;
      START: begin
        if (w_half) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (w_full) begin
          w_shift_nxt[r_bit_idx] = r_s2;
          w_cnt_nxt              = '0;
          w_bit_idx_nxt          = r_bit_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (w_full) begin
          w_cnt_nxt = '0;
          if (r_s2) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
      r_busy    <= (w_next_state != IDLE);
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: directed scenarios plus random frames
// scored against an expected-event queue built from the frames the bench sends.
module tb_uart_recv;

  localparam int BIT_CNT = 16;
  localparam int CW      = 5;
  localparam int LAT     = BIT_CNT / 2 + 9 * BIT_CNT + 3;
  localparam int FRAME   = 10 * BIT_CNT;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_recv #(.BIT_CNT(BIT_CNT), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         t;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_valid_t = -1;
  int         prev_valid_t = -1;
  ev_t        mon_e;
  int         mon_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest outstanding frame the bench sent.
  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      check("pulse_exclusive", 32'(valid & frame_err), 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({valid, frame_err}), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'(frame_err), 32'(mon_e.err));
        if (!mon_e.err) model_data = mon_e.d;
        check("pulse_data", 32'(data), 32'(model_data));
        mon_lat = cyc - mon_e.t;
        check("latency", 32'((mon_lat >= LAT - 1 && mon_lat <= LAT + 1) ? LAT : mon_lat), 32'(LAT));
        if (valid) begin
          prev_valid_t = last_valid_t;
          last_valid_t = cyc;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b1;
    end
  endtask

  // Drives start, 8 data bits LSB first, stop; abort_at >= 0 stops early unscored.
  task automatic send_frame(input logic [7:0] b, input bit stop_b, input int abort_at);
    logic [9:0] bits;
    bits = {stop_b, b, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      if (abort_at >= 0 && i == abort_at) return;
      @(negedge clk);
      din = bits[i / BIT_CNT];
      if (i == 0 && abort_at < 0) exp_q.push_back('{err: !stop_b, d: b, t: cyc});
    end
  endtask

  initial begin
    int gap;
    logic [7:0] rb;
    bit rs;

    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(10);

    send_frame(8'hA5, 1'b1, -1);
    idle(10);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_busy", 32'(busy), 32'h0);
    check("a5_drained", 32'(exp_q.size()), 32'h0);

    repeat (3) begin
      @(negedge clk);
      din = 1'b0;
    end
    idle(2);
    check("glitch_busy_start", 32'(busy), 32'h1);
    idle(30);
    check("glitch_busy_end", 32'(busy), 32'h0);
    check("glitch_data", 32'(data), 32'hA5);

    send_frame(8'h3C, 1'b0, -1);
    idle(5);
    check("ferr_data_kept", 32'(data), 32'hA5);
    check("ferr_drained", 32'(exp_q.size()), 32'h0);
    send_frame(8'h5A, 1'b1, -1);
    idle(10);
    check("after_ferr_data", 32'(data), 32'h5A);

    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(10);
    check("b2b_data", 32'(data), 32'hFF);
    gap = last_valid_t - prev_valid_t;
    check("b2b_gap", 32'((gap >= FRAME - 1 && gap <= FRAME + 1) ? FRAME : gap), 32'(FRAME));
    check("b2b_drained", 32'(exp_q.size()), 32'h0);

    send_frame(8'h96, 1'b1, 5 * BIT_CNT + 5);
    check("mid_busy", 32'(busy), 32'h1);
    din = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    exp_q.delete();
    model_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    check("post_rst_busy", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b1, -1);
    idle(10);
    check("post_rst_data", 32'(data), 32'h81);

    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_data = 8'h00;
    repeat (4) begin
      repeat (10) begin
        @(negedge clk);
        din = 1'b0;
      end
      check("low_rel_busy", 32'(busy), 32'h0);
    end
    check("low_rel_data", 32'(data), 32'h00);
    idle(20);
    send_frame(8'h55, 1'b1, -1);
    idle(10);
    check("low_rel_55", 32'(data), 32'h55);
    check("low_rel_drained", 32'(exp_q.size()), 32'h0);

    for (int k = 0; k < 40; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, -1);
      gap = rs ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      idle(gap);
    end
    idle(20);
    check("rand_drained", 32'(exp_q.size()), 32'h0);
    check("rand_final_data", 32'(data), 32'(model_data));
    check("rand_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- Serial receiver for the 8N1 UART link; consumes the `dout` line produced by the transmit chain (`uart_send` driven by the bit/string counters).
- Synchronises the line, detects the start bit and samples each bit at mid-period.
- Presents each received byte with a one-cycle valid strobe, or flags a framing error.
- Used on the far end of the link or in loopback to check the transmitted string.

Parameters:
- BIT_CNT, 100000: clock cycles per bit period. Must match the transmitter's CNT_MAX. Must be >= 4 and even.
- CW, 17: bit-counter width. Must satisfy 2^CW >= BIT_CNT.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- din  input  1  serial line; idle high; asynchronous to clk
- data  output  8  last correctly framed byte, LSB received first
- valid  output  1  one-cycle pulse; data updated in the same cycle
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, rst=1):
  - Outputs: data=8'h00, valid=0, frame_err=0, busy=0.
  - Internal: FSM=IDLE, cnt=0, bit_idx=0, shift=0.
  - Synchroniser flops and the previous-sample flop reset to 1 (line idle).
- Synchroniser: din -> s1 -> s2. `s` = s2, which is din delayed 2 clk. `s_d` is s delayed 1 clk. All decisions use `s` only.
- FSM states: IDLE, START, DATA, STOP. busy = (state != IDLE).
- IDLE:
  - On s_d=1 and s=0 (falling edge): go to START, cnt<=0.
  - A line held low from reset release never triggers. A fresh falling edge is required.
- START:
  - cnt increments each cycle.
  - At cnt == BIT_CNT/2-1, sample s.
  - If s=0: go to DATA, cnt<=0, bit_idx<=0.
  - If s=1: treat as a glitch and return to IDLE. No output pulse.
- DATA:
  - cnt increments. At cnt == BIT_CNT-1: shift[bit_idx] <= s, cnt<=0, bit_idx<=bit_idx+1.
  - After bit_idx 7 is sampled, go to STOP.
  - Bits are sampled one full period apart, i.e. at each bit centre.
- STOP: at cnt == BIT_CNT-1, sample s.
  - s=1: data<=shift and valid=1 for exactly one cycle.
  - s=0: frame_err=1 for one cycle; data keeps its previous value.
  - Either way: next state IDLE, cnt<=0.
- Back-to-back frames: the FSM returns to IDLE at stop-bit centre, so the next start edge is caught.
  - After a framing error the line is low. A new frame needs s to go high and then fall again.
- Latency: valid rises BIT_CNT/2 + 9*BIT_CNT + 3 cycles (±1) after the din falling edge of the start bit. Bench tolerance is ±1 cycle.
- valid and frame_err are never asserted in the same cycle. Neither is asserted outside STOP->IDLE.
- din changes during a sample are not filtered beyond the synchroniser. A single sample per bit is the decided scheme.
- Reset mid-frame: all state clears immediately and no pulse is emitted. The partial byte is discarded and data returns to 8'h00.
- cnt never exceeds BIT_CNT-1; no wrap-around beyond the period.

Test Plan:
- BIT_CNT=16, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> one valid pulse, data=8'hA5, frame_err=0, busy low after the pulse.
- BIT_CNT=16, 3-cycle low glitch on an idle line -> FSM returns to IDLE at the START check; no valid, no frame_err, data unchanged.
- BIT_CNT=16, frame 0x3C with stop bit 0 -> frame_err pulses once, valid stays 0, data keeps the prior 8'hA5. A following 0x5A frame after the line returns high is received correctly.
- BIT_CNT=16, back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 160±1 cycles apart, data 8'h00 then 8'hFF.
- BIT_CNT=16, rst asserted during DATA bit 4 of a frame -> outputs zero immediately, no pulse. The next full frame 0x81 is received as 8'h81.
- din held low through reset release, then high for 20 cycles, then frame 0x55 -> no activity before the rise; exactly one valid with data=8'h55.
